// File: rtl/soi_pkg.sv
// Shared types and constants for the SOI capture FIFO.
//   soi_state_e : capture FSM states (IDLE, CAPTURE, HALT)
//   soi_rec_t   : record layout {ts, soi} at the default widths
//   DROP_CNT_W  : width of the saturating dropped-record counter
package soi_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int REC_TS_W   = 32;
  localparam int REC_SOI_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HALT    = 2'd2
  } soi_state_e;

  typedef struct packed {
    logic [REC_TS_W-1:0]  ts;
    logic [REC_SOI_W-1:0] soi;
  } soi_rec_t;

endpackage

// File: rtl/soi_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
//   clk, rst_n   : clock, asynchronous active-low reset (pointers only)
//   push         : write request; accepted when not full or when a pop
//                  happens in the same cycle
//   push_data    : record written at the tail
//   pop          : read request; ignored while empty
//   pop_data     : head entry, forced to 0 while empty
//   full, empty  : occupancy flags
//   level        : current occupancy, 0..DEPTH
module soi_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              pop_ok;
  logic              push_ok;

  // Same-index full/empty disambiguated by the extra wrap bit.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign pop_ok  = pop & ~empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO fits.
  assign push_ok = push & (~full | pop_ok);

  assign pop_data = empty ? '0 : mem[rptr[AW-1:0]];

  // Storage is data-only and carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/soi_capture_fifo.sv
// Timestamped change-record capture for a vector of signals of interest.
//   clk, rst_n    : clock, asynchronous active-low reset
//   soi_i         : observed vector, sampled every cycle
//   mask_i        : per-bit change-detect enable (1 = watched)
//   arm_i         : capture runs while high; low->high re-arms
//   rd_ready_i    : consumer accepts head record
//   rd_valid_o    : head record available
//   rd_data_o     : head record {ts, soi}, 0 when empty
//   level_o       : FIFO occupancy
//   overflow_o    : sticky, a record was dropped since the last arm
//   drop_cnt_o    : saturating dropped-record count
//   halted_o      : capture frozen after a full-FIFO drop
module soi_capture_fifo
  import soi_pkg::*;
#(
  parameter int SOI_W        = 8,
  parameter int DEPTH        = 16,
  parameter int TS_W         = 32,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SOI_W-1:0]       soi_i,
  input  logic [SOI_W-1:0]       mask_i,
  input  logic                   arm_i,
  input  logic                   rd_ready_i,
  output logic                   rd_valid_o,
  output logic [TS_W+SOI_W-1:0]  rd_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o,
  output logic                   halted_o
);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [TS_W-1:0]       ts_p0;
  logic [SOI_W-1:0]      prev_p1;
  soi_state_e            state;
  logic                  chg;
  logic                  push_req;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;

  // ---- stage p0: free-running timestamp and previous-sample register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_p0   <= '0;
      prev_p1 <= '0;
    end else begin
      ts_p0   <= ts_p0 + 1'b1;
      prev_p1 <= soi_i;
    end
  end

  assign chg = |((soi_i ^ prev_p1) & mask_i);

  // Arm cycle always attempts the baseline record; CAPTURE pushes on change.
  always_comb begin
    push_req = 1'b0;
    case (state)
      IDLE:    push_req = arm_i;
      CAPTURE: push_req = arm_i & chg;
      default: push_req = 1'b0;
    endcase
  end

  assign pop  = rd_valid_o & rd_ready_i;
  assign drop = push_req & fifo_full & ~pop;

  // ---- stage p1: FSM and drop accounting ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm_i) begin
            state    <= CAPTURE;
            // Counters restart at the arm; a dropped baseline counts as one.
            overflow <= drop;
            drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
          end
        end
        CAPTURE: begin
          if (!arm_i) begin
            state <= IDLE;
          end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
            if (STOP_ON_FULL != 0) state <= HALT;
          end
        end
        HALT: begin
          if (!arm_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign overflow_o = overflow;
  assign drop_cnt_o = drop_cnt;
  assign halted_o   = (state == HALT);
  assign rd_valid_o = ~fifo_empty;

  soi_fifo #(
    .DATA_W (TS_W + SOI_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data ({ts_p0, soi_i}),
    .pop       (rd_ready_i),
    .pop_data  (rd_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o)
  );

endmodule

// File: tb/tb_soi_capture_fifo.sv
// Bench for soi_capture_fifo: two instances (STOP_ON_FULL = 0 and 1) share
// one directed stimulus; each has a queue-based reference model checked on
// every falling edge, plus hand-computed literal expectations.
module tb_soi_capture_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] soi;
  logic [7:0] mask;
  logic       arm;
  logic       rd_ready;

  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [39:0] rec(input int t, input int s);
    soi_pkg::soi_rec_t r;
    r.ts  = 32'(t);
    r.soi = 8'(s);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    logic        rd_valid;
    logic [39:0] rd_data;
    logic [4:0]  level;
    logic        ovf;
    logic [15:0] dcnt;
    logic        halted;

    soi_capture_fifo #(
      .SOI_W        (8),
      .DEPTH        (16),
      .TS_W         (32),
      .STOP_ON_FULL (g)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .soi_i      (soi),
      .mask_i     (mask),
      .arm_i      (arm),
      .rd_ready_i (rd_ready),
      .rd_valid_o (rd_valid),
      .rd_data_o  (rd_data),
      .level_o    (level),
      .overflow_o (ovf),
      .drop_cnt_o (dcnt),
      .halted_o   (halted)
    );

    // Reference model: a record queue plus the arm/halt rules.
    logic [39:0] q[$];
    logic [31:0] mts   = '0;
    logic [7:0]  mprev = '0;
    bit          cap   = 0;
    bit          hlt   = 0;
    bit          movf  = 0;
    logic [15:0] mdcnt = '0;

    always @(posedge clk or negedge rst_n) begin
      bit do_pop, was_full, attempt, from_cap;
      if (!rst_n) begin
        q.delete();
        mts = '0; mprev = '0; cap = 0; hlt = 0; movf = 0; mdcnt = '0;
      end else begin
        do_pop   = (q.size() != 0) && rd_ready;
        was_full = (q.size() == 16);
        attempt  = 0;
        from_cap = 0;
        if (hlt) begin
          if (!arm) hlt = 0;
        end else if (cap) begin
          if (!arm) cap = 0;
          else if (((soi ^ mprev) & mask) != 0) begin
            attempt = 1; from_cap = 1;
          end
        end else if (arm) begin
          cap = 1; attempt = 1; movf = 0; mdcnt = '0;
        end
        if (do_pop) void'(q.pop_front());
        if (attempt) begin
          if (!was_full || do_pop) q.push_back({mts, soi});
          else begin
            movf = 1;
            if (mdcnt != 16'hFFFF) mdcnt = mdcnt + 1'b1;
            if (g == 1 && from_cap) begin cap = 0; hlt = 1; end
          end
        end
        mprev = soi;
        mts   = mts + 1'b1;
      end
    end

    always @(negedge clk) begin
      check($sformatf("u%0d.rd_valid", g), 64'(rd_valid), 64'(q.size() != 0));
      check($sformatf("u%0d.rd_data", g),  64'(rd_data),  (q.size() != 0) ? 64'(q[0]) : 64'd0);
      check($sformatf("u%0d.level", g),    64'(level),    64'(q.size()));
      check($sformatf("u%0d.overflow", g), 64'(ovf),      64'(movf));
      check($sformatf("u%0d.drop_cnt", g), 64'(dcnt),     64'(mdcnt));
      check($sformatf("u%0d.halted", g),   64'(halted),   64'(hlt));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1; soi = 8'h00; mask = 8'hFF; arm = 1'b0; rd_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid0", 64'(u[0].rd_valid), 64'd0);
    check("reset.data0",  64'(u[0].rd_data),  64'd0);
    check("reset.level0", 64'(u[0].level),    64'd0);
    #1 rst_n = 1'b1;

    // Reset and arm: baseline at ts = 10
    repeat (10) step();
    arm = 1'b1; soi = 8'h00;
    step();
    check("arm.valid", 64'(u[0].rd_valid), 64'd1);
    check("arm.level", 64'(u[0].level),    64'd1);
    check("arm.data",  64'(u[0].rd_data),  64'(rec(10, 8'h00)));

    // Masked change: only the low-nibble transition records
    mask = 8'h0F;
    soi = 8'h10; step();
    soi = 8'h11; step();
    check("mask.level", 64'(u[0].level), 64'd2);
    rd_ready = 1'b1; step();
    check("mask.head", 64'(u[0].rd_data), 64'(rec(12, 8'h11)));
    step();
    check("mask.empty", 64'(u[0].rd_valid), 64'd0);
    rd_ready = 1'b0;

    // Overflow: 20 changes at ts 15..34 with no reads
    mask = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      soi = 8'(8'h20 + i);
      step();
    end
    check("ovf.level0",  64'(u[0].level),  64'd16);
    check("ovf.flag0",   64'(u[0].ovf),    64'd1);
    check("ovf.drop0",   64'(u[0].dcnt),   64'd4);
    check("ovf.halted0", 64'(u[0].halted), 64'd0);
    check("halt.halted1",64'(u[1].halted), 64'd1);
    check("halt.drop1",  64'(u[1].dcnt),   64'd1);
    check("halt.level1", 64'(u[1].level),  64'd16);
    check("ovf.head0",   64'(u[0].rd_data), 64'(rec(15, 8'h20)));

    // Full with simultaneous pop and change at ts 35
    soi = 8'h55; rd_ready = 1'b1;
    step();
    check("simul.level0", 64'(u[0].level), 64'd16);
    check("simul.drop0",  64'(u[0].dcnt),  64'd4);
    check("simul.level1", 64'(u[1].level), 64'd15);
    for (int i = 0; i < 15; i++) begin
      check("drain.head0", 64'(u[0].rd_data), 64'(rec(16 + i, 8'h21 + i)));
      step();
    end
    check("drain.tail0",  64'(u[0].rd_data), 64'(rec(35, 8'h55)));
    check("drain.empty1", 64'(u[1].rd_valid), 64'd0);
    check("drain.still_halted1", 64'(u[1].halted), 64'd1);
    step();
    check("drain.empty0", 64'(u[0].level), 64'd0);
    rd_ready = 1'b0;

    // Re-arm after halt
    arm = 1'b0; step();
    check("rearm.unhalt1", 64'(u[1].halted), 64'd0);
    arm = 1'b1; step();
    check("rearm.drop1",  64'(u[1].dcnt),  64'd0);
    check("rearm.ovf0",   64'(u[0].ovf),   64'd0);
    check("rearm.level1", 64'(u[1].level), 64'd1);

    // Mid-capture reset with 5 records queued
    for (int i = 1; i <= 4; i++) begin
      soi = 8'(i);
      step();
    end
    check("mid.level0", 64'(u[0].level), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [39:0] d;
      logic [4:0]  l;
      logic        v;
      d = (k == 0) ? u[0].rd_data  : u[1].rd_data;
      l = (k == 0) ? u[0].level    : u[1].level;
      v = (k == 0) ? u[0].rd_valid : u[1].rd_valid;
      check($sformatf("rst.valid%0d", k), 64'(v), 64'd0);
      check($sformatf("rst.data%0d", k),  64'(d), 64'd0);
      check($sformatf("rst.level%0d", k), 64'(l), 64'd0);
    end
    check("rst.drop0",   64'(u[0].dcnt),   64'd0);
    check("rst.halted1", 64'(u[1].halted), 64'd0);
    step();
    rst_n = 1'b1; arm = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/soi_capture_fifo.md
# soi_capture_fifo

Captures timestamped change records of a vector of signals of interest (SOI) and buffers them for in-order readout by the host-side DPI poll function. It sits directly upstream of the DPI accessor stage. The observed design drives `soi_i`, and the accessor pops records through a valid/ready port. Recording is gated by an arm control, uses a per-bit change mask, and reports overflow explicitly. No record is ever silently lost without being counted.

## Interface
- `SOI_W`, default 8: width of the observed SOI vector.
- `DEPTH`, default 16: number of FIFO records; power of two, at least 2.
- `TS_W`, default 32: width of the free-running timestamp.
- `STOP_ON_FULL`, default 0:
  - 1: capture halts when the FIFO is full.
  - 0: new records are dropped and counted while full.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `soi_i` input SOI_W: signals of interest, sampled every cycle.
- `mask_i` input SOI_W: per-bit enable for change detection (1 = watched).
- `arm_i` input 1: level; capture runs while high.
- `rd_ready_i` input 1: consumer accepts the head record.
- `rd_valid_o` output 1: head record available.
- `rd_data_o` output TS_W+SOI_W: head record, `{ts, soi}`.
- `level_o` output $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow_o` output 1: sticky; at least one record was dropped since the last arm.
- `drop_cnt_o` output 16: dropped-record count, saturates at 0xFFFF.
- `halted_o` output 1: FSM is in HALT.

## Operation
- **Timestamp.** `ts` increments every cycle from reset. It wraps modulo 2^TS_W with no special handling.
- **Previous sample.** `prev` registers `soi_i` every cycle regardless of state.
- **Change detect.** `chg = |((soi_i ^ prev) & mask_i)`.
- **FSM states:**
  - IDLE: no records pushed.
  - CAPTURE: records pushed on change.
  - HALT: frozen, reads still allowed.
- **FSM transitions:**
  - IDLE → CAPTURE on `arm_i` = 1.
    - The arm cycle pushes one baseline record `{ts, soi_i}` unconditionally.
    - `overflow_o` and `drop_cnt_o` clear in that same cycle.
    - The FIFO contents are NOT flushed.
  - CAPTURE → IDLE on `arm_i` = 0. No push in that cycle.
  - CAPTURE → HALT when `STOP_ON_FULL` = 1 and a push is attempted while the FIFO is full with no simultaneous pop. That record is dropped and counted.
  - HALT → IDLE on `arm_i` = 0. Re-arming requires `arm_i` to go low and then high again.
- **Push rule.** A push is attempted when the state is CAPTURE and `chg` = 1. The pushed record is `{ts, soi_i}`, i.e. the current-cycle value and timestamp.
- **Full FIFO.**
  - If a pop happens in the same cycle, the push succeeds.
  - Otherwise the record is dropped, `overflow_o` is set and `drop_cnt_o` increments (saturating).
- **Pop rule.** A pop occurs when `rd_valid_o` and `rd_ready_i` are both 1. The head pointer advances.
- **Read-side independence.** `rd_ready_i` while empty has no effect. Pops are legal in every state.
- **Occupancy.** `level_o` changes by +1, -1 or 0 per cycle. Simultaneous push and pop leaves it unchanged.
- **FIFO pointers.** Read and write pointers are $clog2(DEPTH)+1 bits wide, with wrap-bit full/empty detection.

## Timing
- **Reset values** (asynchronous assertion, synchronous-safe deassertion):
  - FSM in IDLE.
  - `ts`, `prev` and both pointers at 0.
  - `rd_valid_o` = 0, `rd_data_o` = 0, `level_o` = 0.
  - `overflow_o` = 0, `drop_cnt_o` = 0, `halted_o` = 0.
- **Push-to-visibility latency.** A record pushed at edge N is on `rd_data_o` with `rd_valid_o` = 1 after edge N+1. There is no combinational fall-through from `soi_i` to `rd_*`.
- **Head data.** `rd_data_o` is the storage entry at the read pointer and is stable while `rd_valid_o` = 1 and `rd_ready_i` = 0. It is 0 when empty.
- **Back-to-back pops.** One record per cycle is sustained.
- **Mid-operation reset.** Asserting `rst_n` empties the FIFO and returns to IDLE immediately. Partial records are discarded.
- **Mask changes** take effect in the same cycle's `chg`.

## Structure
- **Package `soi_pkg`:**
  - `soi_state_e` enum: IDLE, CAPTURE, HALT.
  - Record struct: `ts`, `soi`.
  - `DROP_CNT_W` = 16 constant.
- **Sub-module `soi_fifo`:** a generic synchronous FIFO with push/pop/full/empty/level and wrap-bit pointers.
- **Top level:** holds the timestamp, `prev`, change detect, FSM and drop accounting.

## Test plan
All scenarios use default parameters.
- **Reset and arm.** Hold reset, release, drive `soi_i` = 0x00 and raise arm at `ts` = 10.
  - Required: one baseline record `{10, 0x00}`.
  - Required: `rd_valid_o` = 1 on the following cycle and `level_o` = 1.
- **Masked change.** With `mask_i` = 0x0F, step `soi_i` 0x00 → 0x10 → 0x11.
  - Required: only the 0x11 transition is recorded.
  - Required: `ts` in the record equals the cycle of the change.
- **Overflow, `STOP_ON_FULL` = 0.** 20 changes with no reads.
  - Required: `level_o` = 16, `overflow_o` = 1, `drop_cnt_o` = 4.
  - Required: the records read back are the first 16, in order.
- **Halt, `STOP_ON_FULL` = 1.** Fill the FIFO, then make one more change.
  - Required: `halted_o` = 1 and `drop_cnt_o` = 1.
  - Required: draining works, and arm low→high restarts capture and clears the counters.
- **Full with simultaneous pop and change.** `level_o` = 16, `rd_ready_i` = 1 and a change in the same cycle.
  - Required: no drop, `level_o` stays 16, and the new record appears at the tail.
- **Mid-capture reset.** Assert `rst_n` low with 5 records queued.
  - Required: all outputs return to their reset values asynchronously and `rd_valid_o` = 0.
